// File: rtl/sram_mem_responder_if.sv
// Request/response channel between the control FSM (master) and the SRAM responder (slave).
interface sram_mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_mem_responder.sv
// Services single-word read/write requests against an asynchronous SRAM with
// programmable read wait, write pulse width and read-to-next-access turnaround.
module sram_mem_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int RD_WAIT  = 2,
  parameter int WR_WAIT  = 2,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  sram_mem_responder_if.slave bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  function automatic int clamp_cyc(input int v);
    return (v < 1) ? 1 : ((v > 15) ? 15 : v);
  endfunction

  localparam logic [3:0] RD_LOAD   = 4'(clamp_cyc(RD_WAIT) - 1);
  localparam logic [3:0] WR_LOAD   = 4'(clamp_cyc(WR_WAIT) - 1);
  localparam logic [3:0] TURN_LOAD = 4'(clamp_cyc(TURN_CYC) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_TURN, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ready_q, ready_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;

  // Every pin value is computed for the state being entered, so the pins are
  // glitch-free flop outputs and line up exactly with the state register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          ce_n_d  = 1'b0;
          if (bus.req_we) begin
            state_d = S_WR_SETUP;
            dq_oe_d = 1'b1;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_LOAD;
            oe_n_d  = 1'b0;
          end
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          rdata_d     = sram_dq;
          rsp_valid_d = 1'b1;
          state_d     = S_TURN;
          cnt_d       = TURN_LOAD;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_LOAD;
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d     = S_WR_HOLD;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          we_n_d = 1'b0;
        end
      end
      S_WR_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign sram_addr     = addr_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_dq       = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule
